mod_addsub_seq: RTL

- Parametrised, digit-serial, multi-cycle adder/subtractor with a start/done handshake; next generation of the fixed-width 256-bit sequential adder.
- Adds three modes: plain subtract, modular add and modular subtract against a runtime modulus P.
- Serves as the field add/sub unit in the ECC point-addition datapath.
- Trades latency for area: one DIGIT-wide carry chain is reused over N = WIDTH/DIGIT cycles per pass.

---
 rtl/mod_addsub_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mod_addsub_seq.sv
// mod_addsub_seq: digit-serial adder/subtractor with optional modular reduction.
// One DIGIT-wide carry chain is reused for N = WIDTH/DIGIT cycles per pass.
// PASS1 forms T = A +/- B (+/- carry-in). PASS2 forms U = T -/+ P for the modular ops.
// Optional build macro: ADDSUB_CONST_TIME_EN. When it is defined, plain ops also run a
// dummy PASS2, so every op takes the same number of cycles.
module mod_addsub_seq #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] P,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef ADDSUB_CONST_TIME_EN
  localparam logic CONST_TIME = 1'b1;
`else
  localparam logic CONST_TIME = 1'b0;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS1 = 2'd1;
  localparam logic [1:0] PASS2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("mod_addsub_seq: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] p_sh;
  logic [WIDTH-1:0] t_reg;
  logic [WIDTH-1:0] u_reg;
  logic             cy;
  logic             c1;

  logic             in_pass2;
  logic             sub;
  logic             last_digit;
  logic             modular_op;
  logic             mod_sel;
  logic [DIGIT-1:0] x;
  logic [DIGIT-1:0] y;
  logic [DIGIT:0]   sum_ext;
  logic [DIGIT-1:0] digit;
  logic             cout;
  logic [WIDTH-1:0] t_shift;
  logic [WIDTH-1:0] t_rot;
  logic [WIDTH-1:0] u_shift;

  // PASS1 subtracts for ops 10/11; PASS2 inverts that, so op 01 subtracts P and op 10 adds it back.
  assign in_pass2   = (state == PASS2);
  assign sub        = op_reg[1] ^ in_pass2;
  assign last_digit = (cnt == CW'(N - 1));
  assign modular_op = (op_reg == 2'b01) || (op_reg == 2'b10);

  // The single shared digit adder. The top bit of sum_ext is the carry-out on add and the borrow-out on subtract.
  assign x       = in_pass2 ? t_reg[DIGIT-1:0] : a_sh[DIGIT-1:0];
  assign y       = in_pass2 ? p_sh[DIGIT-1:0]  : b_sh[DIGIT-1:0];
  assign sum_ext = sub ? ({1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, cy})
                       : ({1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cy});
  assign digit   = sum_ext[DIGIT-1:0];
  assign cout    = sum_ext[DIGIT];

  // Each new digit is shifted in at the MSD end, so the full word is aligned after N steps.
  // In PASS2, T is rotated rather than consumed, so it is intact again when the pass ends.
  assign t_shift = (t_reg >> DIGIT) | (WIDTH'(digit) << (WIDTH - DIGIT));
  assign t_rot   = (t_reg >> DIGIT) | (WIDTH'(t_reg[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign u_shift = (u_reg >> DIGIT) | (WIDTH'(digit) << (WIDTH - DIGIT));

  // Op 01 keeps U when T overflowed or T >= P. Op 10 keeps U only when T went negative.
  assign mod_sel = op_reg[0] ? (c1 | ~cout) : c1;

  assign busy = (state == PASS1) || (state == PASS2);
  assign done = (state == DONE);

  // Control FSM and digit-serial datapath. S/Co are written on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_reg <= 2'b00;
      a_sh   <= '0;
      b_sh   <= '0;
      p_sh   <= '0;
      t_reg  <= '0;
      u_reg  <= '0;
      cy     <= 1'b0;
      c1     <= 1'b0;
      S      <= '0;
      Co     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= PASS1;
            cnt    <= '0;
            op_reg <= op;
            a_sh   <= A;
            b_sh   <= B;
            p_sh   <= P;
            t_reg  <= '0;
            u_reg  <= '0;
            cy     <= (op[0] == op[1]) ? Ci : 1'b0;
            c1     <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        PASS1: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          t_reg <= t_shift;
          cy    <= cout;
          cnt   <= cnt + 1'b1;
          if (last_digit) begin
            c1  <= cout;
            cy  <= 1'b0;
            cnt <= '0;
            if (modular_op || CONST_TIME) begin
              state <= PASS2;
            end else begin
              state <= DONE;
              S     <= t_shift;
              Co    <= cout;
            end
          end
        end
        PASS2: begin
          t_reg <= t_rot;
          p_sh  <= p_sh >> DIGIT;
          u_reg <= u_shift;
          cy    <= cout;
          cnt   <= cnt + 1'b1;
          if (last_digit) begin
            cnt   <= '0;
            state <= DONE;
            if (modular_op) begin
              S  <= mod_sel ? u_shift : t_rot;
              Co <= 1'b0;
            end else begin
              S  <= t_rot;
              Co <= c1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
